// File: rtl/adc_capture_streamer.sv
// ADC capture streamer: sequences the enabled ADC channels, averages
// 2^AVG_LOG2 samples per channel, and streams each averaged result as a
// serial frame {A|ch, HI, LO}.
// Optional feature macro: ADC_STREAM_CHECKSUM_EN appends a CHK byte
// (HDR ^ HI ^ LO), making the frame 4 bytes long.
module adc_capture_streamer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 10,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic [3:0]          channel,
    input  logic                new_sample,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [3:0]          sample_channel,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    input  logic                tx_busy,
    input  logic                tx_block,
    output logic [7:0]          led,
    output logic                overrun
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

`ifdef ADC_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CHK} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, HI, LO} tx_state_t;
`endif

    tx_state_t state;

    logic [ACC_W-1:0]    acc      [NUM_CH];
    logic [CNT_W-1:0]    cnt      [NUM_CH];
    logic [SAMPLE_W-1:0] result_q [NUM_CH];
    logic [NUM_CH-1:0]   pending;

    logic                cur_enabled;
    logic [3:0]          lowest_ch;
    logic [3:0]          next_ch;
    logic [ACC_W-1:0]    cur_acc;
    logic [CNT_W-1:0]    cur_cnt;
    logic                cur_pending;
    logic                accept;
    logic                done;
    logic [ACC_W-1:0]    sum;
    logic [SAMPLE_W-1:0] avg;

    logic                any_pending;
    logic [3:0]          sel_ch;
    logic [SAMPLE_W-1:0] sel_result;
    logic                take;
    logic                can_send;
    logic [3:0]          tx_ch;
    logic [SAMPLE_W-1:0] tx_result;
    logic [7:0]          hdr_byte;
    logic [7:0]          hi_byte;
    logic [7:0]          lo_byte;

    // Channel lookup: enable bit of the current channel, lowest enabled channel, next enabled channel above the current one (wrapping)
    always_comb begin
        cur_enabled = 1'b0;
        lowest_ch   = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel == 4'(i)) cur_enabled = ch_mask[i];
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) lowest_ch = 4'(i);
        end
        next_ch = lowest_ch;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && (4'(i) > channel)) next_ch = 4'(i);
        end
    end

    // Current channel's accumulator state and the averaged result it would produce
    always_comb begin
        cur_acc     = '0;
        cur_cnt     = '0;
        cur_pending = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channel == 4'(i)) begin
                cur_acc     = acc[i];
                cur_cnt     = cnt[i];
                cur_pending = pending[i];
            end
        end
        accept = new_sample && (sample_channel == channel) && cur_enabled;
        sum    = cur_acc + ACC_W'(sample);
        avg    = SAMPLE_W'(sum >> AVG_LOG2);
        done   = accept && (cur_cnt == CNT_LAST);
    end

    // Lowest-numbered pending channel, offered to the transmitter
    always_comb begin
        any_pending = 1'b0;
        sel_ch      = 4'd0;
        sel_result  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pending = 1'b1;
                sel_ch      = 4'(i);
                sel_result  = result_q[i];
            end
        end
        take     = (state == IDLE) && any_pending;
        can_send = !tx_busy && !tx_block && !new_tx_data;
        hdr_byte = {4'hA, tx_ch};
        hi_byte  = 8'(tx_result >> 8);
        lo_byte  = tx_result[7:0];
    end

    // Sequencer: snap to the lowest enabled channel when the current one is disabled, otherwise advance after each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channel <= 4'd0;
        end else if (!cur_enabled) begin
            channel <= lowest_ch;
        end else if (accept) begin
            channel <= next_ch;
        end
    end

    // Accumulate accepted samples, publish completed averages, track pending flags, led and the sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]      <= '0;
                cnt[i]      <= '0;
                result_q[i] <= '0;
            end
            pending <= '0;
            led     <= 8'd0;
            overrun <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && (channel == 4'(i))) begin
                    if (done) begin
                        acc[i]      <= '0;
                        cnt[i]      <= '0;
                        result_q[i] <= avg;
                    end else begin
                        acc[i] <= sum;
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
                if (done && (channel == 4'(i))) begin
                    pending[i] <= 1'b1;
                end else if (take && (sel_ch == 4'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            if (done) begin
                led <= avg[SAMPLE_W-1 -: 8];
                if (cur_pending && !(take && (sel_ch == channel))) overrun <= 1'b1;
            end
        end
    end

    // Transmit FSM: latch a pending result, then send each frame byte with a one-cycle strobe when the link is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= 8'd0;
            new_tx_data <= 1'b0;
            tx_ch       <= 4'd0;
            tx_result   <= '0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        tx_ch     <= sel_ch;
                        tx_result <= sel_result;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (can_send) begin
                        tx_data     <= hdr_byte;
                        new_tx_data <= 1'b1;
                        state       <= HI;
                    end
                end
                HI: begin
                    if (can_send) begin
                        tx_data     <= hi_byte;
                        new_tx_data <= 1'b1;
                        state       <= LO;
                    end
                end
                LO: begin
                    if (can_send) begin
                        tx_data     <= lo_byte;
                        new_tx_data <= 1'b1;
`ifdef ADC_STREAM_CHECKSUM_EN
                        state       <= CHK;
`else
                        state       <= IDLE;
`endif
                    end
                end
`ifdef ADC_STREAM_CHECKSUM_EN
                CHK: begin
                    if (can_send) begin
                        tx_data     <= hdr_byte ^ hi_byte ^ lo_byte;
                        new_tx_data <= 1'b1;
                        state       <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_streamer.sv
// Self-checking bench for adc_capture_streamer: a vector table for the basic
// sequencing/averaging case, hand-written sequences for flow control,
// overrun and mid-frame reset, and a randomized run against a reference model.
// Honours ADC_STREAM_CHECKSUM_EN when building expected frames.
module tb_adc_capture_streamer;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 10;
    localparam int AVG_LOG2 = 2;
    localparam int GAP      = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_CH-1:0]   ch_mask = '0;
    logic [3:0]          channel;
    logic                new_sample = 1'b0;
    logic [SAMPLE_W-1:0] sample = '0;
    logic [3:0]          sample_channel = '0;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy = 1'b0;
    logic                tx_block = 1'b0;
    logic [7:0]          led;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit prev_pulse = 1'b0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] sch;
        logic [9:0] value;
        logic [3:0] exp_ch;
        bit         led_chk;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[12];

    adc_capture_streamer #(
        .NUM_CH(NUM_CH),
        .SAMPLE_W(SAMPLE_W),
        .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ch_mask(ch_mask),
        .channel(channel),
        .new_sample(new_sample),
        .sample(sample),
        .sample_channel(sample_channel),
        .tx_data(tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy(tx_busy),
        .tx_block(tx_block),
        .led(led),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Capture every transmitted byte and require an idle cycle between strobes
    always @(negedge clk) begin
        if (new_tx_data) begin
            got.push_back(tx_data);
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("[TB] FAIL strobe_gap: strobe in two consecutive cycles, required an idle cycle between");
            end
        end
        prev_pulse = new_tx_data;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushFrame(input int ch, input int res);
        logic [7:0] h, hi, lo;
        h  = 8'(8'hA0 | ch);
        hi = 8'((res >> 8) & 8'hFF);
        lo = 8'(res & 8'hFF);
        exp_q.push_back(h);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
`ifdef ADC_STREAM_CHECKSUM_EN
        exp_q.push_back(h ^ hi ^ lo);
`endif
    endtask

    task automatic compareFrames(input string name);
        checkOutput({name, "_count"}, 16'(got.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checkOutput(name, {8'd0, got[i]}, {8'd0, exp_q[i]});
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] sch, input logic [9:0] v);
        @(negedge clk);
        ch_mask        = m;
        sample_channel = sch;
        sample         = v;
        new_sample     = 1'b1;
        @(negedge clk);
        new_sample     = 1'b0;
    endtask

    task automatic doReset(input logic [3:0] m);
        @(negedge clk);
        rst_n      = 1'b0;
        ch_mask    = m;
        tx_busy    = 1'b0;
        tx_block   = 1'b0;
        new_sample = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        got.delete();
        exp_q.delete();
    endtask

    task automatic waitStrobe(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (new_tx_data) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: no strobe within 60 cycles, required one", name);
    endtask

    function automatic int lowestOf(input logic [3:0] m);
        for (int i = 0; i < NUM_CH; i++) if (((m >> i) & 4'd1) != 4'd0) return i;
        return 0;
    endfunction

    function automatic int nextOf(input logic [3:0] m, input int c);
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (c + k) % NUM_CH;
            if (((m >> idx) & 4'd1) != 4'd0) return idx;
        end
        return c;
    endfunction

    // Main test sequence
    initial begin
        int mch;
        int sum[NUM_CH];
        int cnt[NUM_CH];
        logic [3:0] m;
        logic [3:0] sch;
        logic [9:0] v;
        bit mismatch;
        int n;

        vecs[0]  = '{4'b0101, 4'd0, 10'd100,   4'd2, 1'b0, 8'h00};
        vecs[1]  = '{4'b0101, 4'd1, 10'h3FF,   4'd2, 1'b0, 8'h00};
        vecs[2]  = '{4'b0101, 4'd2, 10'd500,   4'd0, 1'b0, 8'h00};
        vecs[3]  = '{4'b0101, 4'd0, 10'd101,   4'd2, 1'b0, 8'h00};
        vecs[4]  = '{4'b0101, 4'd2, 10'd500,   4'd0, 1'b0, 8'h00};
        vecs[5]  = '{4'b0101, 4'd0, 10'd102,   4'd2, 1'b0, 8'h00};
        vecs[6]  = '{4'b0101, 4'd2, 10'd500,   4'd0, 1'b0, 8'h00};
        vecs[7]  = '{4'b0101, 4'd0, 10'd103,   4'd2, 1'b1, 8'h19};
        vecs[8]  = '{4'b0101, 4'd2, 10'd500,   4'd0, 1'b1, 8'h7D};
        vecs[9]  = '{4'b0000, 4'd0, 10'd7,     4'd0, 1'b0, 8'h00};
        vecs[10] = '{4'b1000, 4'd0, 10'd5,     4'd3, 1'b0, 8'h00};
        vecs[11] = '{4'b0101, 4'd3, 10'd9,     4'd0, 1'b0, 8'h00};

        // Outputs held at reset values while rst_n is low
        ch_mask = 4'b0101;
        idle(2);
        checkOutput("reset_channel", {12'd0, channel}, 16'd0);
        checkOutput("reset_tx_data", {8'd0, tx_data}, 16'd0);
        checkOutput("reset_strobe", {15'd0, new_tx_data}, 16'd0);
        checkOutput("reset_led", {8'd0, led}, 16'd0);
        checkOutput("reset_overrun", {15'd0, overrun}, 16'd0);
        rst_n = 1'b1;
        idle(2);

        // Table-driven sequencing and averaging
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].mask, vecs[i].sch, vecs[i].value);
            if (vecs[i].led_chk) checkOutput("vec_led", {8'd0, led}, {8'd0, vecs[i].exp_led});
            idle(GAP);
            checkOutput("vec_channel", {12'd0, channel}, {12'd0, vecs[i].exp_ch});
        end
        idle(20);
        pushFrame(0, 101);
        pushFrame(2, 500);
        compareFrames("vec_bytes");

        // tx_block held during HI stalls the frame without losing bytes
        doReset(4'b0001);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'd0, 10'd968);
        waitStrobe("blk_hdr");
        tx_block = 1'b1;
        @(negedge clk);
        n = got.size();
        idle(50);
        checkOutput("blk_hold", 16'(got.size()), 16'(n));
        tx_block = 1'b0;
        idle(20);
        pushFrame(0, 968);
        compareFrames("blk_bytes");

        // Overrun: third ch1 result overwrites an unsent second result
        doReset(4'b0010);
        checkOutput("ovr_start_ch", {12'd0, channel}, 16'd1);
        tx_busy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(4'b0010, 4'd1, 10'(200 + 100 * r));
                idle(2);
            end
            if (r == 1) checkOutput("ovr_not_yet", {15'd0, overrun}, 16'd0);
        end
        checkOutput("ovr_flag", {15'd0, overrun}, 16'd1);
        checkOutput("ovr_led", {8'd0, led}, 16'd100);
        checkOutput("ovr_no_tx", 16'(got.size()), 16'd0);
        tx_busy = 1'b0;
        idle(30);
        checkOutput("ovr_sticky", {15'd0, overrun}, 16'd1);
        pushFrame(1, 200);
        pushFrame(1, 400);
        compareFrames("ovr_bytes");

        // Reset after the HDR byte abandons the frame
        doReset(4'b0001);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'd0, 10'd341);
        waitStrobe("rst_hdr");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_channel", {12'd0, channel}, 16'd0);
        checkOutput("rst_tx_data", {8'd0, tx_data}, 16'd0);
        checkOutput("rst_strobe", {15'd0, new_tx_data}, 16'd0);
        checkOutput("rst_led", {8'd0, led}, 16'd0);
        checkOutput("rst_overrun", {15'd0, overrun}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        checkOutput("rst_bytes_count", 16'(got.size()), 16'd1);
        if (got.size() >= 1) checkOutput("rst_hdr_byte", {8'd0, got[0]}, 16'hA0);
        got.delete();

        // Randomized run against the reference model
        doReset(4'b1100);
        checkOutput("rand_start_ch", {12'd0, channel}, 16'd2);
        m   = 4'b1100;
        mch = 2;
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = 0;
            cnt[i] = 0;
        end
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                m = 4'($urandom_range(1, 15));
                ch_mask = m;
                if (((m >> mch) & 4'd1) == 4'd0) mch = lowestOf(m);
                @(negedge clk);
            end
            checkOutput("rand_channel", {12'd0, channel}, 16'(mch));
            mismatch = ($urandom_range(0, 3) == 0);
            v = 10'($urandom_range(0, 1023));
            sch = mismatch ? 4'((mch + $urandom_range(1, 15)) % 16) : 4'(mch);
            applyStimulus(m, sch, v);
            if (!mismatch) begin
                sum[mch] += int'(v);
                cnt[mch]++;
                if (cnt[mch] == (1 << AVG_LOG2)) begin
                    pushFrame(mch, sum[mch] >> AVG_LOG2);
                    checkOutput("rand_led", {8'd0, led}, 16'((sum[mch] >> AVG_LOG2) >> (SAMPLE_W - 8)));
                    sum[mch] = 0;
                    cnt[mch] = 0;
                end
                mch = nextOf(m, mch);
            end
            idle(GAP);
        end
        idle(20);
        checkOutput("rand_overrun", {15'd0, overrun}, 16'd0);
        compareFrames("rand_bytes");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
